// File: rtl/axi_lite_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_reg_pkg
//  Description : Shared constants and FSM state types for the AXI4-Lite
//                register bank.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_lite_reg_pkg;

   localparam int         DATA_WIDTH  = 32;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [0:0] {
      W_IDLE = 1'b0,
      W_RESP = 1'b1
   } wr_state_t;

   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/axi_lite_addr_decode.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_addr_decode
//  Description : Byte address -> register index, with in-range and
//                writable flags. Address bits [1:0] are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_addr_decode
   import axi_lite_reg_pkg::*;
#(
   parameter int                  NUM_REGS   = 16,
   parameter int                  ADDR_WIDTH = 10,
   parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic [ADDR_WIDTH-3:0] o_idx,
   output logic                  o_in_range,
   output logic                  o_writable
);

   localparam int IDX_W = ADDR_WIDTH - 2;
   localparam int PAD_W = 2 ** IDX_W;

   // Mask padded to the full index space so any index selects a defined bit;
   // indices past NUM_REGS read as 0 and are rejected by the range check.
   localparam logic [PAD_W-1:0] c_ro_pad = PAD_W'(RO_MASK);

   logic w_unused_lsb;

   assign o_idx        = i_addr[ADDR_WIDTH-1:2];
   assign o_in_range   = ({1'b0, o_idx} < (IDX_W + 1)'(NUM_REGS));
   assign o_writable   = o_in_range && !c_ro_pad[o_idx];
   assign w_unused_lsb = ^i_addr[1:0];

endmodule
`default_nettype wire

// File: rtl/axi_lite_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_reg_bank
//  Description : AXI4-Lite slave register bank. Bus writes land in a flat
//                packed register vector; reads return register contents or,
//                for read-only slots, the sampled status_in slice.
//                Optional macro AXI_REG_BANK_WSTRB_EN enables byte-lane
//                write strobes (otherwise every write replaces the word).
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_reg_bank
   import axi_lite_reg_pkg::*;
#(
   parameter int                             NUM_REGS    = 16,
   parameter int                             ADDR_WIDTH  = 10,
   parameter logic [NUM_REGS-1:0]            RO_MASK     = '0,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
   input  logic                           s_axi_awvalid,
   output logic                           s_axi_awready,
   input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
   input  logic [3:0]                     s_axi_wstrb,
   input  logic                           s_axi_wvalid,
   output logic                           s_axi_wready,
   output logic [1:0]                     s_axi_bresp,
   output logic                           s_axi_bvalid,
   input  logic                           s_axi_bready,
   input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
   input  logic                           s_axi_arvalid,
   output logic                           s_axi_arready,
   output logic [DATA_WIDTH-1:0]          s_axi_rdata,
   output logic [1:0]                     s_axi_rresp,
   output logic                           s_axi_rvalid,
   input  logic                           s_axi_rready,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
   output logic [NUM_REGS-1:0]            wr_pulse
);

   localparam int IDX_W = ADDR_WIDTH - 2;

   // ---------------- write path signals ----------------
   wr_state_t               r_wstate, w_wstate_nxt;
   logic                    r_aw_held, r_w_held, w_aw_held_nxt, w_w_held_nxt;
   logic                    r_awready, r_wready, r_bvalid;
   logic                    w_awready_nxt, w_wready_nxt, w_bvalid_nxt;
   logic [1:0]              r_bresp;
   logic [NUM_REGS-1:0]     r_wr_pulse;
   logic [ADDR_WIDTH-1:0]   r_awaddr;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic                    w_aw_hs, w_w_hs, w_commit;
   logic [ADDR_WIDTH-1:0]   w_wr_addr;
   logic [DATA_WIDTH-1:0]   w_wr_data, w_wr_mask;
   logic [IDX_W-1:0]        w_wr_idx;
   logic                    w_wr_range_unused, w_wr_writable;
   logic [NUM_REGS-1:0]     w_wr_sel;
   logic [NUM_REGS*DATA_WIDTH-1:0] w_regs;

   // ---------------- read path signals ----------------
   rd_state_t               r_rstate, w_rstate_nxt;
   logic                    r_arready, r_rvalid, w_arready_nxt, w_rvalid_nxt;
   logic [DATA_WIDTH-1:0]   r_rdata, w_rd_reg, w_rd_stat;
   logic [1:0]              r_rresp;
   logic                    w_ar_hs;
   logic [IDX_W-1:0]        w_rd_idx;
   logic                    w_rd_in_range, w_rd_writable;

   assign w_aw_hs   = s_axi_awvalid && r_awready;
   assign w_w_hs    = s_axi_wvalid  && r_wready;
   assign w_ar_hs   = s_axi_arvalid && r_arready;

   // A channel arriving this cycle is used directly so a same-cycle pair
   // (or the late half of a split pair) commits on its own handshake edge.
   assign w_wr_addr = w_aw_hs ? s_axi_awaddr : r_awaddr;
   assign w_wr_data = w_w_hs  ? s_axi_wdata  : r_wdata;

`ifdef AXI_REG_BANK_WSTRB_EN
   logic [3:0] r_wstrb, w_wr_strb;
   assign w_wr_strb = w_w_hs ? s_axi_wstrb : r_wstrb;
   assign w_wr_mask = {{8{w_wr_strb[3]}}, {8{w_wr_strb[2]}},
                       {8{w_wr_strb[1]}}, {8{w_wr_strb[0]}}};

   // Hold the strobe alongside the captured write data
   always_ff @(posedge clk) begin
      if (rst)         r_wstrb <= '0;
      else if (w_w_hs) r_wstrb <= s_axi_wstrb;
   end
`else
   logic w_unused_wstrb;
   assign w_unused_wstrb = ^s_axi_wstrb;
   assign w_wr_mask      = '1;
`endif

   axi_lite_addr_decode #(
      .NUM_REGS   (NUM_REGS),
      .ADDR_WIDTH (ADDR_WIDTH),
      .RO_MASK    (RO_MASK)
   ) u_aw_decode (
      .i_addr     (w_wr_addr),
      .o_idx      (w_wr_idx),
      .o_in_range (w_wr_range_unused),
      .o_writable (w_wr_writable)
   );

   axi_lite_addr_decode #(
      .NUM_REGS   (NUM_REGS),
      .ADDR_WIDTH (ADDR_WIDTH),
      .RO_MASK    (RO_MASK)
   ) u_ar_decode (
      .i_addr     (s_axi_araddr),
      .o_idx      (w_rd_idx),
      .o_in_range (w_rd_in_range),
      .o_writable (w_rd_writable)
   );

   // One-hot select of the register targeted by a writable write
   always_comb begin
      w_wr_sel = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         w_wr_sel[i] = w_wr_writable && (w_wr_idx == IDX_W'(i));
      end
   end

   // Write FSM next-state and ready/valid decisions
   always_comb begin
      w_wstate_nxt  = r_wstate;
      w_aw_held_nxt = r_aw_held;
      w_w_held_nxt  = r_w_held;
      w_awready_nxt = 1'b0;
      w_wready_nxt  = 1'b0;
      w_bvalid_nxt  = r_bvalid;
      w_commit      = 1'b0;
      case (r_wstate)
         W_IDLE: begin
            if (w_aw_hs) w_aw_held_nxt = 1'b1;
            if (w_w_hs)  w_w_held_nxt  = 1'b1;
            if (w_aw_held_nxt && w_w_held_nxt) begin
               w_commit      = 1'b1;
               w_wstate_nxt  = W_RESP;
               w_aw_held_nxt = 1'b0;
               w_w_held_nxt  = 1'b0;
               w_bvalid_nxt  = 1'b1;
            end else begin
               w_awready_nxt = !w_aw_held_nxt;
               w_wready_nxt  = !w_w_held_nxt;
            end
         end
         W_RESP: begin
            if (s_axi_bready) begin
               w_wstate_nxt  = W_IDLE;
               w_bvalid_nxt  = 1'b0;
               w_awready_nxt = 1'b1;
               w_wready_nxt  = 1'b1;
            end
         end
         default: w_wstate_nxt = W_IDLE;
      endcase
   end

   // Write FSM state and handshake registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wstate  <= W_IDLE;
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
      end else begin
         r_wstate  <= w_wstate_nxt;
         r_aw_held <= w_aw_held_nxt;
         r_w_held  <= w_w_held_nxt;
         r_awready <= w_awready_nxt;
         r_wready  <= w_wready_nxt;
         r_bvalid  <= w_bvalid_nxt;
      end
   end

   // Capture each write channel payload as it is accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         r_awaddr <= '0;
         r_wdata  <= '0;
      end else begin
         if (w_aw_hs) r_awaddr <= s_axi_awaddr;
         if (w_w_hs)  r_wdata  <= s_axi_wdata;
      end
   end

   // Write response code and single-cycle commit strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bresp    <= RESP_OKAY;
         r_wr_pulse <= '0;
      end else begin
         r_wr_pulse <= w_commit ? w_wr_sel : '0;
         if (w_commit) r_bresp <= w_wr_writable ? RESP_OKAY : RESP_SLVERR;
      end
   end

   genvar gi;
   for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (RO_MASK[gi]) begin : g_ro
         assign w_regs[gi*DATA_WIDTH +: DATA_WIDTH] = '0;
      end else begin : g_rw
         logic [DATA_WIDTH-1:0] r_word;
         // Register word: reset value, then masked update on commit
         always_ff @(posedge clk) begin
            if (rst)
               r_word <= RESET_VALUE[gi*DATA_WIDTH +: DATA_WIDTH];
            else if (w_commit && w_wr_sel[gi])
               r_word <= (r_word & ~w_wr_mask) | (w_wr_data & w_wr_mask);
         end
         assign w_regs[gi*DATA_WIDTH +: DATA_WIDTH] = r_word;
      end
   end

   // Select the addressed register word and status word for a read
   always_comb begin
      w_rd_reg  = '0;
      w_rd_stat = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (w_rd_idx == IDX_W'(i)) begin
            w_rd_reg  = w_regs[i*DATA_WIDTH +: DATA_WIDTH];
            w_rd_stat = status_in[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Read FSM next-state and ready/valid decisions
   always_comb begin
      w_rstate_nxt  = r_rstate;
      w_arready_nxt = 1'b0;
      w_rvalid_nxt  = r_rvalid;
      case (r_rstate)
         R_IDLE: begin
            if (w_ar_hs) begin
               w_rstate_nxt = R_DATA;
               w_rvalid_nxt = 1'b1;
            end else begin
               w_arready_nxt = 1'b1;
            end
         end
         R_DATA: begin
            if (s_axi_rready) begin
               w_rstate_nxt  = R_IDLE;
               w_rvalid_nxt  = 1'b0;
               w_arready_nxt = 1'b1;
            end
         end
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   // Read FSM state and handshake registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rstate  <= R_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
      end else begin
         r_rstate  <= w_rstate_nxt;
         r_arready <= w_arready_nxt;
         r_rvalid  <= w_rvalid_nxt;
      end
   end

   // Read payload is sampled once at the AR handshake and then held
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata <= '0;
         r_rresp <= RESP_OKAY;
      end else if (w_ar_hs) begin
         if (!w_rd_in_range) begin
            r_rdata <= '0;
            r_rresp <= RESP_SLVERR;
         end else begin
            r_rdata <= w_rd_writable ? w_rd_reg : w_rd_stat;
            r_rresp <= RESP_OKAY;
         end
      end
   end

   assign s_axi_awready = r_awready;
   assign s_axi_wready  = r_wready;
   assign s_axi_bvalid  = r_bvalid;
   assign s_axi_bresp   = r_bresp;
   assign s_axi_arready = r_arready;
   assign s_axi_rvalid  = r_rvalid;
   assign s_axi_rdata   = r_rdata;
   assign s_axi_rresp   = r_rresp;
   assign regs_out      = w_regs;
   assign wr_pulse      = r_wr_pulse;

endmodule
`default_nettype wire

// File: doc/axi_lite_reg_bank.md
# axi_lite_reg_bank

AXI4-Lite slave register bank that turns bus writes into a flat packed register vector and returns a packed status vector on reads. It sits directly upstream of the array-unpack stage: `regs_out` is sliced downstream into `NUM_REGS` 32-bit words. `status_in` arrives from the array-pack stage. Module name is `axi_lite_reg_bank`.

## Interface
- `NUM_REGS`, 16: number of 32-bit registers (1..256).
- `ADDR_WIDTH`, 10: byte-address width; must be ≥ clog2(NUM_REGS)+2.
- `RO_MASK`, 0: NUM_REGS bits; bit i=1 makes register i read-only, sourced from `status_in`.
- `RESET_VALUE`, 0: NUM_REGS*32 bits; reset contents, packed with register i at bits [32i+31:32i].

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_axi_awaddr` in ADDR_WIDTH, `s_axi_awvalid` in 1, `s_axi_awready` out 1: write address channel.
- `s_axi_wdata` in 32, `s_axi_wstrb` in 4, `s_axi_wvalid` in 1, `s_axi_wready` out 1: write data channel.
- `s_axi_bresp` out 2, `s_axi_bvalid` out 1, `s_axi_bready` in 1: write response channel.
- `s_axi_araddr` in ADDR_WIDTH, `s_axi_arvalid` in 1, `s_axi_arready` out 1: read address channel.
- `s_axi_rdata` out 32, `s_axi_rresp` out 2, `s_axi_rvalid` out 1, `s_axi_rready` in 1: read data channel.
- `regs_out`  out  NUM_REGS*32  packed register contents; register i at [32i+31:32i].
- `status_in`  in  NUM_REGS*32  packed read-only values, same layout.
- `wr_pulse`  out  NUM_REGS  one-cycle strobe per register on a committed write.

## Operation
- Register index = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored. Index ≥ NUM_REGS is out of range.
- Write FSM states:
  - `W_IDLE`: awready=wready=1. AW and W are captured independently, in either order or in the same cycle.
    - A captured channel drops its ready until the other channel arrives.
    - When both are held, the write commits and the FSM enters `W_RESP`.
  - `W_RESP`: bvalid=1; awready=wready=0. On bready, return to `W_IDLE`.
- Write commit:
  - In range and writable: register updated, `wr_pulse[i]`=1 for exactly the commit cycle, bresp=OKAY (2'b00).
  - Out of range or RO: no state change, no pulse, bresp=SLVERR (2'b10).
- Read FSM states:
  - `R_IDLE`: arready=1. On the AR handshake, rdata/rresp are registered and the FSM enters `R_DATA`.
  - `R_DATA`: rvalid=1, arready=0; rdata/rresp held stable until rready.
- Read data:
  - RW register: returns the register value.
  - RO register: returns the `status_in` slice sampled at the AR handshake.
  - Out of range: rdata=0, rresp=SLVERR.
- Read and write channels are fully independent. A read accepted in the same cycle as a write commit to the same register returns the pre-write value.
- Reset:
  - `regs_out`=RESET_VALUE with RO slices forced to 0.
  - All ready/valid outputs 0 during rst; readies rise the cycle after rst deasserts.
  - bresp=rresp=0, rdata=0, `wr_pulse`=0.
  - Both FSMs return to IDLE and any captured half-transaction is discarded, including mid-response.

## Timing
- Write, AW+W in the same cycle at edge N: `regs_out` updated, `wr_pulse` high, bvalid high, all visible after edge N.
- Write, AW at N and W at N+k: commit at N+k.
- Read latency: AR at edge N -> rvalid high after edge N. Back-to-back reads: one per two cycles minimum.
- Outputs are registered; no combinational path from any input to any output.
- Stall: bvalid/rvalid stay high with stable payload while the corresponding ready is 0.

## Configuration
- `AXI_REG_BANK_WSTRB_EN` defined: byte lane b written only where wstrb[b]=1; wstrb=0 still commits, pulses, and returns OKAY.
- Undefined: wstrb ignored; every write replaces the full 32-bit word.

## Structure
- Package `axi_lite_reg_pkg`:
  - `DATA_WIDTH`=32, `RESP_OKAY`, `RESP_SLVERR`.
  - Write-state and read-state enum typedefs.
- Sub-module `axi_lite_addr_decode`: addr -> index plus in_range/writable flags. Instantiated twice, once for AW and once for AR.

## Test plan
- Reset with RESET_VALUE reg2=0xCAFE0000 -> regs_out[95:64]=0xCAFE0000; reads of all RW registers match RESET_VALUE.
- AW then W three cycles later to 0x08, data 0x12345678 -> single wr_pulse[2], bresp=OKAY, read 0x08 returns 0x12345678.
- Write to index NUM_REGS (0x40 at default) -> bresp=SLVERR, regs_out unchanged; read of 0x40 -> rdata=0, rresp=SLVERR.
- RO_MASK bit 5 set, status_in slice 5=0xA5A5A5A5 -> read 0x14 returns 0xA5A5A5A5; write 0x14 -> SLVERR, no pulse.
- bready and rready held low 10 cycles -> bvalid/rvalid and payload stable, no new AW/AR accepted; rst asserted mid-stall -> all valids 0 next cycle.
- WSTRB_EN: reg 1 = 0xFFFFFFFF, write 0x00000000 with wstrb=4'b0101 -> reads 0xFF00FF00; without the macro -> reads 0x00000000.
